fir_out_formatter: RTL and testbench



---
 rtl/fir_out_formatter.sv | 164 ++++++++++++++++
 tb/tb_fir_out_formatter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_formatter.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_formatter
// Description : Output formatter for the 16-tap FIR stage. Optionally
//               decimates the Q2.30 sample stream, rounds (half toward +inf)
//               and saturates each kept sample to Q1.15, then queues the
//               results in a FIFO presented on a valid/ready interface.
// Ports       : clk, reset (async, active-low), clear (sync soft clear)
//               in_valid/in_data      : Q2.30 input samples
//               out_valid/out_ready/out_data : Q1.15 output handshake
//               fifo_level            : FIFO occupancy
//               drop_pulse            : kept sample lost to a full FIFO
//               ovf_sticky/sat_sticky : sticky drop / saturation flags
// Revision    : 1.0 - initial release
// ============================================================================
module fir_out_formatter #(
    parameter int DEC_FACTOR = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int SHIFT      = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic [31:0]                   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          drop_pulse,
    output logic                          ovf_sticky,
    output logic                          sat_sticky
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_DW = (DEC_FACTOR > 1) ? $clog2(DEC_FACTOR) : 1;
    localparam logic [c_DW-1:0]   c_DCNT_LAST = c_DW'(DEC_FACTOR - 1);
    localparam logic [c_AW:0]     c_FULL      = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic signed [32:0] c_RND      = 33'sd1 <<< (SHIFT - 1);
    localparam logic signed [32:0] c_MAX      = 33'sd32767;
    localparam logic signed [32:0] c_MIN      = -33'sd32768;

    // Decimation and stage 1
    logic [c_DW-1:0]     r_dcnt;
    logic                r_s1_v;
    logic [15:0]         r_s1_data;

    // FIFO state
    logic [15:0]         r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]     r_wptr;
    logic [c_AW-1:0]     r_rptr;
    logic [c_AW:0]       r_level;
    logic [15:0]         r_last;
    logic                r_drop;
    logic                r_ovf;
    logic                r_sat;

    logic                w_keep;
    logic signed [32:0]  w_sum;
    logic signed [32:0]  w_shift;
    logic                w_hi;
    logic                w_lo;
    logic [15:0]         w_fmt;
    logic                w_pop;
    logic                w_full;
    logic                w_wr;
    logic                w_drop;

    assign w_keep = in_valid && (r_dcnt == '0);

    // One guard bit above the 32-bit input so the rounding add cannot wrap.
    assign w_sum   = $signed({in_data[31], in_data}) + c_RND;
    assign w_shift = w_sum >>> SHIFT;
    assign w_hi    = (w_shift > c_MAX);
    assign w_lo    = (w_shift < c_MIN);

    always_comb begin
        w_fmt = w_shift[15:0];
        if (w_hi) begin
            w_fmt = 16'h7FFF;
        end else if (w_lo) begin
            w_fmt = 16'h8000;
        end
    end

    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_full    = (r_level == c_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr      = r_s1_v && (!w_full || w_pop);
    assign w_drop    = r_s1_v && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dcnt    <= '0;
            r_s1_v    <= 1'b0;
            r_s1_data <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_last    <= '0;
            r_drop    <= 1'b0;
            r_ovf     <= 1'b0;
            r_sat     <= 1'b0;
        end else if (clear) begin
            r_dcnt    <= '0;
            r_s1_v    <= 1'b0;
            r_s1_data <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_last    <= '0;
            r_drop    <= 1'b0;
            r_ovf     <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            if (in_valid) begin
                r_dcnt <= (r_dcnt == c_DCNT_LAST) ? '0 : r_dcnt + 1'b1;
            end

            r_s1_v <= w_keep;
            if (w_keep) begin
                r_s1_data <= w_fmt;
                if (w_hi || w_lo) begin
                    r_sat <= 1'b1;
                end
            end

            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                // Remember the popped word so out_data holds it once empty.
                r_last <= r_mem[r_rptr];
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            r_drop <= w_drop;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_wr && !clear) begin
            r_mem[r_wptr] <= r_s1_data;
        end
    end

    assign out_data   = out_valid ? r_mem[r_rptr] : r_last;
    assign fifo_level = r_level;
    assign drop_pulse = r_drop;
    assign ovf_sticky = r_ovf;
    assign sat_sticky = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_formatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_out_formatter
// Description : Self-checking bench for fir_out_formatter. One instance with
//               DEC_FACTOR=1 and one with DEC_FACTOR=3 share all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_out_formatter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        v1, v3;
    logic [15:0] d1, d3;
    logic [3:0]  lvl1, lvl3;
    logic        drop1, drop3, ovf1, ovf3, sat1, sat3;

    int total = 0;
    int bad   = 0;

    logic [15:0] q1[$];
    logic [15:0] q3[$];
    logic        mon1_en = 1'b0;
    logic        mon3_en = 1'b0;
    logic [15:0] e1, e3;

    always #5 clk = ~clk;

    fir_out_formatter #(.DEC_FACTOR(1), .FIFO_DEPTH(8), .SHIFT(15)) u_dut1 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(v1), .out_ready(out_ready), .out_data(d1),
        .fifo_level(lvl1), .drop_pulse(drop1),
        .ovf_sticky(ovf1), .sat_sticky(sat1)
    );

    fir_out_formatter #(.DEC_FACTOR(3), .FIFO_DEPTH(8), .SHIFT(15)) u_dut3 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(v3), .out_ready(out_ready), .out_data(d3),
        .fifo_level(lvl3), .drop_pulse(drop3),
        .ovf_sticky(ovf3), .sat_sticky(sat3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Scoreboard: compare the head word on every cycle a pop will occur.
    always @(negedge clk) begin
        if (mon1_en && v1 && out_ready) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop1_unexpected: got 0x%0h expected no output", d1);
            end else begin
                e1 = q1.pop_front();
                chk("pop1_data", {16'h0, d1}, {16'h0, e1});
            end
        end
        if (mon3_en && v3 && out_ready) begin
            if (q3.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop3_unexpected: got 0x%0h expected no output", d3);
            end else begin
                e3 = q3.pop_front();
                chk("pop3_data", {16'h0, d3}, {16'h0, e3});
            end
        end
    end

    typedef struct {
        logic [31:0] din;
        logic [15:0] dout;
        logic        sat;
    } vec_t;

    vec_t vecs[6];
    int   drops;
    int   dm;

    initial begin
        vecs[0] = '{32'h2000_0000, 16'h4000, 1'b0};
        vecs[1] = '{32'h0000_4000, 16'h0001, 1'b0};
        vecs[2] = '{32'h0000_3FFF, 16'h0000, 1'b0};
        vecs[3] = '{32'hFFFF_C000, 16'h0000, 1'b0};
        vecs[4] = '{32'h4000_0000, 16'h7FFF, 1'b1};
        vecs[5] = '{32'h8000_0000, 16'h8000, 1'b1};

        reset     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", {31'h0, v1}, 32'h0);
        chk("rst_out_data", {16'h0, d1}, 32'h0);
        chk("rst_level", {28'h0, lvl1}, 32'h0);
        chk("rst_flags", {29'h0, drop1, ovf1, sat1}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single samples, two-cycle latency, rounding and saturation
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            tick();
            in_valid = 1'b0;
            chk("lat_not_early", {31'h0, v1}, 32'h0);
            tick();
            chk("lat_valid", {31'h0, v1}, 32'h1);
            chk("vec_data", {16'h0, d1}, {16'h0, vecs[i].dout});
            chk("vec_sat_sticky", {31'h0, sat1}, {31'h0, vecs[i].sat});
            tick();
            chk("vec_drained", {31'h0, v1}, 32'h0);
        end
        do_clear();
        chk("clear_sat", {31'h0, sat1}, 32'h0);
        chk("clear_level", {28'h0, lvl1}, 32'h0);

        // Decimation by 3 with gaps in in_valid
        dm = 0;
        mon3_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k) << 15;
            if (dm == 0) q3.push_back(16'(k));
            dm = (dm == 2) ? 0 : dm + 1;
            tick();
            if (k == 2 || k == 5) begin
                in_valid = 1'b0;
                tick();
                tick();
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && q3.size() != 0; i++) tick();
        for (int i = 0; i < 4; i++) tick();
        chk("dec3_all_seen", q3.size(), 32'h0);
        mon3_en = 1'b0;

        // Overflow: 10 samples into a stalled 8-deep FIFO
        out_ready = 1'b0;
        do_clear();
        drops = 0;
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k) << 15;
            tick();
            if (drop1) drops++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (drop1) drops++;
        end
        chk("ovf_drop_count", drops, 32'd2);
        chk("ovf_level", {28'h0, lvl1}, 32'd8);
        chk("ovf_sticky", {31'h0, ovf1}, 32'h1);
        for (int k = 1; k <= 8; k++) q1.push_back(16'(k));
        mon1_en   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && q1.size() != 0; i++) tick();
        chk("ovf_drain_done", q1.size(), 32'h0);
        tick();
        chk("ovf_valid_fall", {31'h0, v1}, 32'h0);
        mon1_en = 1'b0;

        // Full FIFO: write and read in the same cycle
        out_ready = 1'b0;
        do_clear();
        chk("clear_ovf", {31'h0, ovf1}, 32'h0);
        for (int k = 11; k <= 18; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k) << 15;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("full_level", {28'h0, lvl1}, 32'd8);
        for (int k = 11; k <= 19; k++) q1.push_back(16'(k));
        in_valid = 1'b1;
        in_data  = 32'd19 << 15;
        tick();
        in_valid  = 1'b0;
        mon1_en   = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("full_rw_no_drop", {31'h0, drop1}, 32'h0);
        chk("full_rw_level", {28'h0, lvl1}, 32'd8);
        out_ready = 1'b1;
        for (int i = 0; i < 30 && q1.size() != 0; i++) tick();
        chk("full_rw_drain_done", q1.size(), 32'h0);
        chk("full_rw_ovf", {31'h0, ovf1}, 32'h0);
        mon1_en = 1'b0;

        // Asynchronous reset with entries queued
        out_ready = 1'b0;
        do_clear();
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k) << 15;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_level", {28'h0, lvl1}, 32'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, v1}, 32'h0);
        chk("async_rst_level", {28'h0, lvl1}, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0005_0000;
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_rst_valid1", {31'h0, v1}, 32'h1);
        chk("post_rst_data1", {16'h0, d1}, 32'h000A);
        chk("post_rst_valid3", {31'h0, v3}, 32'h1);
        chk("post_rst_data3", {16'h0, d3}, 32'h000A);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
